// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared encodings and constants for the instruction memory responder
//
// Holds the FSM state encoding, the NOP word returned on error responses
// and the width of the optional statistics counters (INST_MEM_STATS_EN).
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam int          STAT_W = 16;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - 2^DEPTH_LOG2 x 32 instruction storage
//
// Synchronous write, asynchronous read, no reset on the contents.
// Ports:
//   i_clk      clock, rising edge
//   i_we       write enable
//   i_waddr    write word index
//   i_wdata    write data
//   i_raddr    read word index
//   o_rdata    read data (combinational from i_raddr)
module imem_array #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - instruction-fetch responder with wait states and a load port
//
// Accepts one byte-addressed fetch at a time, returns the 32-bit word
// 1+WAIT_CYCLES clock edges after the accept edge, and holds the response
// until the requester takes it. Misaligned or out-of-range addresses
// return NOP with o_err set. Optional macro INST_MEM_STATS_EN adds
// saturating request/error counters.
// Ports:
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_req_valid, o_req_ready, i_addr         fetch request handshake and byte address
//   o_rsp_valid, i_rsp_ready, o_inst, o_err  response handshake, word and error flag
//   i_ld_we, i_ld_addr, i_ld_data            load-port word write
//   o_req_cnt, o_err_cnt    accepted / errored request counts (INST_MEM_STATS_EN only)
module inst_mem_responder
  import inst_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [31:0]           i_addr,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_inst,
  output logic                  o_err,
  input  logic                  i_ld_we,
  input  logic [DEPTH_LOG2-1:0] i_ld_addr,
  input  logic [31:0]           i_ld_data
`ifdef INST_MEM_STATS_EN
  ,
  output logic [STAT_W-1:0]     o_req_cnt,
  output logic [STAT_W-1:0]     o_err_cnt
`endif
);

  localparam int              CW       = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WAIT_CYCLES);

  state_e                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic                    r_pend_err;
  logic [31:0]             r_inst;
  logic                    r_err;

  logic                    w_accept;
  logic                    w_addr_err;
  logic [31:0]             w_rdata;

  assign w_accept   = (r_state == ST_IDLE) && i_req_valid;
  assign w_addr_err = (i_addr[1:0] != 2'b00) || (i_addr[31:DEPTH_LOG2+2] != '0);

  imem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (i_ld_we),
    .i_waddr (i_ld_addr),
    .i_wdata (i_ld_data),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  // WAIT is always visited and lasts WAIT_CYCLES+1 cycles (counter runs
  // WAIT_CYCLES..0), giving accept-to-valid of 1+WAIT_CYCLES edges even
  // for WAIT_CYCLES=0. The word is captured on the edge entering RESP, so a
  // load-port write on that same edge is not seen (read-before-write).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_pend_err <= 1'b0;
      r_inst     <= NOP;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_idx      <= i_addr[DEPTH_LOG2+1:2];
            r_pend_err <= w_addr_err;
            r_cnt      <= CNT_LOAD;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_inst  <= r_pend_err ? NOP : w_rdata;
            r_err   <= r_pend_err;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_inst      = r_inst;
  assign o_err       = r_err;

`ifdef INST_MEM_STATS_EN
  logic [STAT_W-1:0] r_req_cnt;
  logic [STAT_W-1:0] r_err_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_accept) begin
      if (r_req_cnt != '1) begin
        r_req_cnt <= r_req_cnt + 1'b1;
      end
      if (w_addr_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign o_req_cnt = r_req_cnt;
  assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - scoreboard bench for inst_mem_responder
module tb_inst_mem_responder;

  localparam int DL = 8;
  localparam int W  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_addr;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_inst;
  logic        o_err;
  logic        i_ld_we;
  logic [7:0]  i_ld_addr;
  logic [31:0] i_ld_data;
`ifdef INST_MEM_STATS_EN
  logic [15:0] o_req_cnt;
  logic [15:0] o_err_cnt;
  int          exp_req_cnt = 0;
  int          exp_err_cnt = 0;
`endif

  always #5 clk = ~clk;

  inst_mem_responder #(
    .DEPTH_LOG2  (DL),
    .WAIT_CYCLES (W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_addr      (i_addr),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_inst      (o_inst),
    .o_err       (o_err),
    .i_ld_we     (i_ld_we),
    .i_ld_addr   (i_ld_addr),
    .i_ld_data   (i_ld_data)
`ifdef INST_MEM_STATS_EN
    ,
    .o_req_cnt   (o_req_cnt),
    .o_err_cnt   (o_err_cnt)
`endif
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem_m [256];
  exp_t        sb [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: word-aligned addresses below 1 KB read memory, anything else is NOP + error.
  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    int   idx;
    e.err = ((a % 4) != 0) || (a >= 32'd1024);
    idx   = int'(a / 4);
    e.inst = e.err ? 32'h0 : mem_m[idx];
    return e;
  endfunction

  // Monitor: checks hold-stability under backpressure and pops on every handshake.
  logic        hold_v = 1'b0;
  logic [31:0] hold_inst;
  logic        hold_err;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else if (o_rsp_valid) begin
      if (hold_v) begin
        chk("hold_inst", o_inst, hold_inst);
        chk("hold_err", {31'b0, o_err}, {31'b0, hold_err});
      end
      if (i_rsp_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp inst=%h err=%b (no expected entry)", o_inst, o_err);
        end else begin
          e = sb.pop_front();
          chk("rsp_inst", o_inst, e.inst);
          chk("rsp_err", {31'b0, o_err}, {31'b0, e.err});
        end
        hold_v = 1'b0;
      end else begin
        hold_v    = 1'b1;
        hold_inst = o_inst;
        hold_err  = o_err;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input int idx, input logic [31:0] data);
    i_ld_we   = 1'b1;
    i_ld_addr = idx[7:0];
    i_ld_data = data;
    cyc();
    i_ld_we   = 1'b0;
    mem_m[idx] = data;
  endtask

  // Waits (bounded) for o_req_ready at a negedge; returns 1 if seen.
  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = o_req_ready;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_ready_timeout got=0 exp=1 at %0t", $time);
    end
  endtask

  // One full transaction; optional load-port write on the edge that enters RESP.
  task automatic do_req(input logic [31:0] a, input int bp, input bit collide,
                        input logic [31:0] cdata);
    bit ok;
    int cidx;
    i_req_valid = 1'b1;
    i_addr      = a;
    wait_ready(ok);
    if (!ok) begin
      i_req_valid = 1'b0;
      return;
    end
    sb.push_back(model(a));
`ifdef INST_MEM_STATS_EN
    exp_req_cnt++;
    if (model(a).err) exp_err_cnt++;
`endif
    cyc();
    i_req_valid = 1'b0;
    i_addr      = $urandom;
    cidx        = int'(a / 4) % 256;
    for (int k = 1; k <= W + 1; k++) begin
      if (collide && k == W + 1) begin
        i_ld_we   = 1'b1;
        i_ld_addr = cidx[7:0];
        i_ld_data = cdata;
      end
      cyc();
      if (collide && k == W + 1) begin
        i_ld_we     = 1'b0;
        mem_m[cidx] = cdata;
      end
      chk("lat_rsp_valid", {31'b0, o_rsp_valid}, (k == W + 1) ? 32'd1 : 32'd0);
      chk("busy_req_ready", {31'b0, o_req_ready}, 32'd0);
    end
    for (int k = 0; k < bp; k++) cyc();
    i_rsp_ready = 1'b1;
    cyc();
    i_rsp_ready = 1'b0;
    chk("post_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    chk("post_req_ready", {31'b0, o_req_ready}, 32'd1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", {31'b0, o_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_err", {31'b0, o_err}, 32'd0);
    sb.delete();
`ifdef INST_MEM_STATS_EN
    exp_req_cnt = 0;
    exp_err_cnt = 0;
`endif
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [31:0] a;
    int          r;
    i_req_valid = 1'b0;
    i_addr      = 32'h0;
    i_rsp_ready = 1'b0;
    i_ld_we     = 1'b0;
    i_ld_addr   = 8'h0;
    i_ld_data   = 32'h0;
    rst_n       = 1'b0;
    #2;
    apply_reset();
    for (int i = 0; i < 256; i++) ld(i, $urandom);

    // Basic read with 5 cycles of backpressure.
    ld(3, 32'h8C22_0004);
    do_req(32'h0000_000C, 5, 1'b0, 32'h0);
    // Misaligned and out of range.
    do_req(32'h0000_000E, 0, 1'b0, 32'h0);
    do_req(32'h0000_0400, 1, 1'b0, 32'h0);

    // Reset while in WAIT: transaction abandoned, no response.
    i_req_valid = 1'b1;
    i_addr      = 32'h0000_000C;
    wait_ready(ok);
    cyc();
    i_req_valid = 1'b0;
    apply_reset();
    chk("after_rst_req_ready", {31'b0, o_req_ready}, 32'd1);
    do_req(32'h0000_000C, 0, 1'b0, 32'h0);

    // Reset while a response is being held: valid drops at once.
    i_req_valid = 1'b1;
    i_addr      = 32'h0000_0010;
    wait_ready(ok);
    cyc();
    i_req_valid = 1'b0;
    for (int k = 0; k < W + 1; k++) cyc();
    chk("held_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
    apply_reset();

    // Write collision on the RESP-entry edge, then re-read.
    do_req(32'h0000_000C, 0, 1'b1, 32'h0000_0000);
    do_req(32'h0000_000C, 0, 1'b0, 32'h0);

    // Randomized traffic with interleaved loads.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) ld($urandom_range(0, 255), $urandom);
      r = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, 255)) * 4;
      else if (r < 8) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
      else            a = $urandom | 32'h0000_0400;
      do_req(a, $urandom_range(0, 3), $urandom_range(0, 4) == 0, $urandom);
    end

`ifdef INST_MEM_STATS_EN
    chk("req_cnt", {16'b0, o_req_cnt}, 32'(exp_req_cnt));
    chk("err_cnt", {16'b0, o_err_cnt}, 32'(exp_err_cnt));
`endif

    cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
